conv_encoder_k3: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder that sits directly upstream of the Viterbi decoder (`decoder_sys`). It accepts bytes from the UART receiver (`async_receiver`) through a small byte FIFO and serialises each byte MSB-first into the encoder. It emits one 2-bit encoded symbol every `SYM_DIV` clocks on the decoder's `encoded_bits` input. A flush request appends two zero tail bits so the trellis terminates in state 00.

---
 rtl/conv_encoder_k3.sv | 135 +++++++++++++
 tb/tb_conv_encoder_k3.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder (g0=7, g1=5) fed from a byte FIFO.
// Bytes go MSB-first, one symbol per SYM_DIV clocks; flush appends a 00 tail.
module conv_encoder_k3 #(
  parameter int FIFO_DEPTH = 4,
  parameter int SYM_DIV    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  input  logic                          flush,
  output logic                          sym_valid,
  output logic [1:0]                    sym,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(SYM_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [7:0]      sreg;
  logic [2:0]      bit_cnt;
  logic [DW-1:0]   div;
  logic            s1;
  logic            s2;
  logic            flush_pending;

  logic            full;
  logic            pop;
  logic            push;
  logic            tick;
  logic            u;

  always_comb begin
    full = (fifo_count == CW'(FIFO_DEPTH));
    pop  = (state == LOAD);
    push = byte_valid && (!full || pop);
    tick = (div == DW'(SYM_DIV - 1));
    u    = (state == SHIFT) ? sreg[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      sreg          <= '0;
      bit_cnt       <= '0;
      div           <= '0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      flush_pending <= 1'b0;
      sym           <= 2'b00;
      sym_valid     <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      busy      <= (state != IDLE) || (fifo_count != '0) || flush_pending;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      if (byte_valid && !push) overflow <= 1'b1;
      if (flush) flush_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state <= LOAD;
          end else if (flush_pending) begin
            state   <= TAIL;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          sreg    <= mem[rd_ptr];
          bit_cnt <= '0;
          div     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sym       <= {u ^ s1 ^ s2, u ^ s2};
            sym_valid <= 1'b1;
            s1        <= u;
            s2        <= s1;
            sreg      <= {sreg[6:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
            div       <= '0;
            if (bit_cnt == 3'd7)
              state <= (fifo_count != '0) ? LOAD : IDLE;
          end else begin
            div <= div + DW'(1);
          end
        end
        TAIL: begin
          // bit_cnt 0 is a one-cycle setup, 1 and 2 emit the tail bits
          if (bit_cnt == 3'd0) begin
            bit_cnt <= 3'd1;
            div     <= '0;
          end else if (tick) begin
            sym       <= {u ^ s1 ^ s2, u ^ s2};
            sym_valid <= 1'b1;
            s1        <= u;
            s2        <= s1;
            bit_cnt   <= bit_cnt + 3'd1;
            div       <= '0;
            if (bit_cnt == 3'd2) begin
              state         <= IDLE;
              flush_pending <= flush;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: vector table, directed corner sequences
// and randomized byte/flush traffic against a generator-polynomial model.
module tb_conv_encoder_k3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       flush = 1'b0;
  logic       sym_valid;
  logic [1:0] sym;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  conv_encoder_k3 #(.FIFO_DEPTH(4), .SYM_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .flush      (flush),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] got[$];
  int         got_cyc[$];
  logic [1:0] exp_q[$];
  bit         hist[$];
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk)
    if (!rst && sym_valid) begin
      got.push_back(sym);
      got_cyc.push_back(cyc);
    end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each output bit is the parity of the last three input bits masked by
  // its generator polynomial (7 and 5 octal).
  function automatic void model_bit(input bit b);
    logic [2:0] w;
    w[2] = b;
    w[1] = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
    w[0] = (hist.size() > 1) ? hist[hist.size()-2] : 1'b0;
    exp_q.push_back({^(w & 3'o7), ^(w & 3'o5)});
    hist.push_back(b);
    if (hist.size() > 2) void'(hist.pop_front());
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) model_bit(b[i]);
  endfunction

  function automatic void model_tail();
    model_bit(1'b0);
    model_bit(1'b0);
    hist.delete();
  endfunction

  task automatic clear_q();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
    clear_q();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] b, output int t);
    @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    t = cyc;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_syms(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, " count"}, got.size(), n);
  endtask

  task automatic cmp_syms(input string name);
    check({name, " total"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        check($sformatf("%s sym%0d", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [7:0] b;
    logic [7:0] rb[6];
    int n;

    vt[0] = '{8'hB0, 16'hE170};
    vt[1] = '{8'h01, 16'h0003};
    vt[2] = '{8'hFF, 16'hDAAA};
    vt[3] = '{8'h80, 16'hEC00};
    vt[4] = '{8'h00, 16'h0000};

    idle(2);
    check("reset sym", sym, 2'b00);
    check("reset sym_valid", sym_valid, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset fifo_count", fifo_count, 3'd0);
    check("reset busy", busy, 1'b0);

    foreach (vt[i]) begin
      do_reset();
      pulse_byte(vt[i].data, t0);
      check($sformatf("vec%0d fifo_count", i), fifo_count, 3'd1);
      wait_syms(8, 300, $sformatf("vec%0d", i));
      for (int k = 0; k < 8; k++)
        if (k < got.size())
          check($sformatf("vec%0d sym%0d", i, k), got[k],
                vt[i].exp[15-2*k -: 2]);
      if (got.size() >= 8) begin
        check($sformatf("vec%0d latency", i), got_cyc[0] - t0, 19);
        for (int k = 1; k < 8; k++)
          check($sformatf("vec%0d gap%0d", i, k),
                got_cyc[k] - got_cyc[k-1], 16);
      end
      idle(1);
      check($sformatf("vec%0d busy end", i), busy, 1'b0);
    end

    // 0x01 with a flush arriving mid-byte
    do_reset();
    pulse_byte(8'h01, t0);
    model_byte(8'h01);
    idle(60);
    pulse_flush();
    model_tail();
    wait_syms(10, 400, "flush");
    idle(60);
    cmp_syms("flush");
    if (got.size() >= 10) begin
      check("flush tail gap", got_cyc[8] - got_cyc[7], 18);
      check("flush tail spacing", got_cyc[9] - got_cyc[8], 16);
    end
    clear_q();
    pulse_byte(8'h01, t0);
    model_byte(8'h01);
    wait_syms(8, 300, "after tail");
    cmp_syms("after tail");

    // back-to-back bytes carry encoder state
    do_reset();
    @(posedge clk);
    #1 byte_valid = 1'b1;
    byte_data = 8'hB0;
    @(posedge clk);
    #1 byte_data = 8'h01;
    @(posedge clk);
    #1 byte_valid = 1'b0;
    model_byte(8'hB0);
    model_byte(8'h01);
    wait_syms(16, 600, "b2b");
    cmp_syms("b2b");
    if (got.size() >= 9)
      check("b2b gap", got_cyc[8] - got_cyc[7], 17);

    // six consecutive strobes into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 byte_valid = 1'b1;
      byte_data = rb[i];
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
    for (int i = 0; i < 5; i++) model_byte(rb[i]);
    check("ovf set", overflow, 1'b1);
    check("ovf fifo_count", fifo_count, 3'd4);
    wait_syms(40, 1000, "ovf");
    idle(60);
    cmp_syms("ovf");
    check("ovf sticky", overflow, 1'b1);

    // asynchronous reset during the 4th symbol
    do_reset();
    pulse_byte(8'hB0, t0);
    wait_syms(3, 200, "abort pre");
    pulse_byte(8'hFF, t0);
    pulse_flush();
    check("abort queued", fifo_count, 3'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort sym", sym, 2'b00);
    check("abort sym_valid", sym_valid, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort fifo_count", fifo_count, 3'd0);
    check("abort overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
    clear_q();
    idle(80);
    check("abort silent", got.size(), 0);
    pulse_byte(8'hB0, t0);
    model_byte(8'hB0);
    wait_syms(8, 300, "abort redo");
    idle(30);
    cmp_syms("abort redo");

    // flush from idle, second flush absorbed during tail
    do_reset();
    pulse_flush();
    model_tail();
    wait_syms(1, 100, "idle tail first");
    pulse_flush();
    idle(80);
    cmp_syms("idle tail");
    check("idle tail busy", busy, 1'b0);

    // randomized traffic, encoder state carried between rounds
    clear_q();
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        pulse_byte(b, t0);
        model_byte(b);
        idle($urandom_range(0, 40));
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_flush();
        model_tail();
      end
      wait_syms(exp_q.size(), exp_q.size() * 20 + 100,
                $sformatf("rand%0d", it));
      idle(60);
      cmp_syms($sformatf("rand%0d", it));
      clear_q();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
